// File: rtl/ch376_seq_if.sv
// CPU port and byte-wide SPI master handshake of the CH376 sequencer.
interface ch376_seq_if;
    logic       rd;
    logic       wr;
    logic       a0;
    logic [7:0] din;
    logic [7:0] dout;
    logic       int_n;
    logic       sdcs;
    logic       spi_start;
    logic [7:0] spi_tx;
    logic       spi_done;
    logic [7:0] spi_rx;

    // Environment side: CPU plus SPI byte shifter.
    modport master (
        output rd, wr, a0, din, int_n, spi_done, spi_rx,
        input  dout, sdcs, spi_start, spi_tx
    );

    // Sequencer side.
    modport slave (
        input  rd, wr, a0, din, int_n, spi_done, spi_rx,
        output dout, sdcs, spi_start, spi_tx
    );
endinterface

// File: rtl/ch376_seq.sv
// CH376 SPI sequencer: frames CPU command/data accesses into chip-select
// bounded SPI byte transfers, with post-command wait and dummy-byte fetches.
module ch376_seq #(
    parameter int unsigned GAP_CYC      = 8,
    parameter int unsigned SETUP_CYC    = 2,
    parameter int unsigned CMD_WAIT_CYC = 80
) (
    input  logic        clk,
    input  logic        reset,
    ch376_seq_if.slave  bus
);
    localparam int unsigned MAX_AB  = (GAP_CYC > SETUP_CYC) ? GAP_CYC : SETUP_CYC;
    localparam int unsigned MAX_CYC = (MAX_AB > CMD_WAIT_CYC) ? MAX_AB : CMD_WAIT_CYC;
    localparam int unsigned CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

    // A zero-length parameter still occupies one cycle, hence the clamp at 0.
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'((SETUP_CYC == 0) ? 0 : SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] CWAIT_LAST = CNT_W'((CMD_WAIT_CYC == 0) ? 0 : CMD_WAIT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_GAP, S_SETUP, S_XFER, S_CWAIT, S_OPEN
    } state_t;

    typedef enum logic [1:0] {
        K_CMD, K_DATA, K_FETCH
    } kind_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd_q, wr_q;
    logic             int_meta_q, int_sync_q;
    logic             hold_full_q, hold_full_d;
    kind_t            hold_kind_q, hold_kind_d;
    logic [7:0]       hold_byte_q, hold_byte_d;
    kind_t            xfer_kind_q, xfer_kind_d;
    logic             ovr_q, ovr_d;
    logic [7:0]       rx_q, rx_d;
    logic             sdcs_q, sdcs_d;
    logic             spi_start_q, spi_start_d;
    logic [7:0]       spi_tx_q, spi_tx_d;

    logic             rd_rise, wr_rise;
    logic             start_xfer, discard;
    logic             busy;
    logic [7:0]       status;

    assign rd_rise = bus.rd & ~rd_q;
    assign wr_rise = bus.wr & ~wr_q;

    assign busy   = hold_full_q | ~((state_q == S_IDLE) | (state_q == S_OPEN));
    assign status = {int_sync_q, 4'b0000, ovr_q, ~sdcs_q, busy};

    // CPU read mux; combinational so the value tracks rd/a0 directly.
    assign bus.dout = bus.rd ? (bus.a0 ? status : rx_q) : 8'h00;

    assign bus.sdcs      = sdcs_q;
    assign bus.spi_start = spi_start_q;
    assign bus.spi_tx    = spi_tx_q;

    // Next-state, holding register and flag updates.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_full_d = hold_full_q;
        hold_kind_d = hold_kind_q;
        hold_byte_d = hold_byte_q;
        xfer_kind_d = xfer_kind_q;
        ovr_d       = ovr_q;
        rx_d        = rx_q;
        spi_start_d = 1'b0;
        spi_tx_d    = spi_tx_q;
        start_xfer  = 1'b0;
        discard     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hold_full_q) begin
                    if (hold_kind_q == K_CMD) begin
                        state_d = S_GAP;
                        cnt_d   = '0;
                    end else begin
                        discard = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d    = S_XFER;
                    start_xfer = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_XFER: begin
                if (bus.spi_done) begin
                    rx_d = bus.spi_rx;
                    if (xfer_kind_q == K_CMD) begin
                        state_d = S_CWAIT;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_OPEN;
                    end
                end
            end
            S_CWAIT: begin
                if (cnt_q == CWAIT_LAST) begin
                    state_d = S_OPEN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_OPEN: begin
                if (hold_full_q) begin
                    if (hold_kind_q == K_CMD) begin
                        state_d = S_GAP;
                        cnt_d   = '0;
                    end else begin
                        state_d    = S_XFER;
                        start_xfer = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Frame is open from SETUP through OPEN; sdcs is registered from the next state.
        sdcs_d = (state_d == S_IDLE) || (state_d == S_GAP);

        if (start_xfer) begin
            spi_start_d = 1'b1;
            spi_tx_d    = hold_byte_q;
            xfer_kind_d = hold_kind_q;
            hold_full_d = 1'b0;
        end

        if (discard) begin
            hold_full_d = 1'b0;
            ovr_d       = 1'b1;
        end

        // Status read clears ovr; a same-cycle overflow below re-sets it.
        if (rd_rise && bus.a0) begin
            ovr_d = discard;
        end

        // CPU access into the 1-deep holding register; wr wins over rd.
        if (wr_rise) begin
            if (hold_full_q) begin
                ovr_d = 1'b1;
            end else begin
                hold_full_d = 1'b1;
                hold_kind_d = bus.a0 ? K_CMD : K_DATA;
                hold_byte_d = bus.din;
            end
        end else if (rd_rise && !bus.a0 && !sdcs_q) begin
            if (hold_full_q) begin
                ovr_d = 1'b1;
            end else begin
                hold_full_d = 1'b1;
                hold_kind_d = K_FETCH;
                hold_byte_d = 8'hFF;
            end
        end
    end

    // State, edge detectors, synchronizer and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            int_meta_q  <= 1'b1;
            int_sync_q  <= 1'b1;
            hold_full_q <= 1'b0;
            hold_kind_q <= K_CMD;
            hold_byte_q <= 8'h00;
            xfer_kind_q <= K_CMD;
            ovr_q       <= 1'b0;
            rx_q        <= 8'h00;
            sdcs_q      <= 1'b1;
            spi_start_q <= 1'b0;
            spi_tx_q    <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_q        <= bus.rd;
            wr_q        <= bus.wr;
            int_meta_q  <= bus.int_n;
            int_sync_q  <= int_meta_q;
            hold_full_q <= hold_full_d;
            hold_kind_q <= hold_kind_d;
            hold_byte_q <= hold_byte_d;
            xfer_kind_q <= xfer_kind_d;
            ovr_q       <= ovr_d;
            rx_q        <= rx_d;
            sdcs_q      <= sdcs_d;
            spi_start_q <= spi_start_d;
            spi_tx_q    <= spi_tx_d;
        end
    end
endmodule
